// File: rtl/tpiu_frame_demux.sv
// TPIU formatter frame demultiplexer.
// Turns 16-byte trace frames into (stream ID, byte) pairs.
module tpiu_frame_demux #(
  parameter bit DROP_NULL_ID = 1'b1
) (
  input  logic         traceClkin,
  input  logic         rst,
  input  logic         FrAvail,
  input  logic [127:0] Frame,
  output logic         dataValid,
  input  logic         dataReady,
  output logic [7:0]   dataByte,
  output logic [6:0]   dataId,
  output logic         busy,
  output logic         overflow,
  output logic [7:0]   lostFrames
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic         last_av_q, last_av_d;
  logic [127:0] work_q, work_d;
  logic [127:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic [3:0]   idx_q, idx_d;
  logic [6:0]   cur_id_q, cur_id_d;
  logic         def_vld_q, def_vld_d;
  logic [6:0]   def_id_q, def_id_d;
  logic         dv_q, dv_d;
  logic [7:0]   db_q, db_d;
  logic [6:0]   did_q, did_d;
  logic         ovf_q, ovf_d;
  logic [7:0]   lost_q, lost_d;

  logic         new_frame;
  logic         running;
  logic [127:0] shifted;
  logic [7:0]   slot_byte;
  logic [7:0]   aux_byte;
  logic         aux;
  logic         is_idc;
  logic [7:0]   slot_data;
  logic         null_drop;
  logic         emit;
  logic         advance;
  logic         last;
  logic         work_free;

  // Slot decode, handshake, buffering and ID tracking.
  always_comb begin
    state_d    = state_q;
    last_av_d  = FrAvail;
    work_d     = work_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    cur_id_d   = cur_id_q;
    def_vld_d  = def_vld_q;
    def_id_d   = def_id_q;
    dv_d       = dv_q & ~dataReady;
    db_d       = db_q;
    did_d      = did_q;
    ovf_d      = 1'b0;
    lost_d     = lost_q;

    new_frame = FrAvail != last_av_q;
    running   = state_q == S_RUN;
    shifted   = work_q << {idx_q, 3'b000};
    slot_byte = shifted[127:120];
    aux_byte  = work_q[7:0];
    aux       = aux_byte[idx_q[3:1]];
    is_idc    = ~idx_q[0] & slot_byte[0];
    slot_data = idx_q[0] ? slot_byte
                         : {slot_byte[7:1], aux};
    null_drop = DROP_NULL_ID && (cur_id_q == 7'd0);
    emit      = running & ~is_idc & ~null_drop;
    advance   = running & (~emit | ~dv_q | dataReady);
    last      = advance & (idx_q == 4'd14);

    if (advance) begin
      idx_d = idx_q + 4'd1;
      if (emit) begin
        dv_d  = 1'b1;
        db_d  = slot_data;
        did_d = cur_id_q;
      end
      if (last && def_vld_q) begin
        cur_id_d  = def_id_q;
        def_vld_d = 1'b0;
      end
      if (is_idc) begin
        if (aux && !last) begin
          def_vld_d = 1'b1;
          def_id_d  = slot_byte[7:1];
        end else begin
          cur_id_d = slot_byte[7:1];
        end
      end else if (idx_q[0] && def_vld_q) begin
        cur_id_d  = def_id_q;
        def_vld_d = 1'b0;
      end
    end

    if (last) begin
      idx_d = 4'd0;
      if (pend_vld_q) begin
        work_d     = pend_q;
        pend_vld_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end

    work_free = ~running | (last & ~pend_vld_q);

    if (new_frame) begin
      if (work_free) begin
        work_d  = Frame;
        idx_d   = 4'd0;
        state_d = S_RUN;
      end else if (!pend_vld_q || last) begin
        pend_d     = Frame;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_av_q  <= 1'b0;
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= '0;
      cur_id_q   <= '0;
      def_vld_q  <= 1'b0;
      def_id_q   <= '0;
      dv_q       <= 1'b0;
      db_q       <= '0;
      did_q      <= '0;
      ovf_q      <= 1'b0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_av_q  <= last_av_d;
      work_q     <= work_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      cur_id_q   <= cur_id_d;
      def_vld_q  <= def_vld_d;
      def_id_q   <= def_id_d;
      dv_q       <= dv_d;
      db_q       <= db_d;
      did_q      <= did_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
    end
  end

  assign dataValid  = dv_q;
  assign dataByte   = db_q;
  assign dataId     = did_q;
  assign busy       = state_q == S_RUN;
  assign overflow   = ovf_q;
  assign lostFrames = lost_q;

endmodule

// File: tb/tb_tpiu_frame_demux.sv
// Scoreboard bench for tpiu_frame_demux.
// Directed frames push expected pairs; a monitor pops them.
module tb_tpiu_frame_demux;

  logic         traceClkin = 1'b0;
  logic         rst = 1'b1;
  logic         FrAvail = 1'b0;
  logic [127:0] Frame = '0;
  logic         dataValid;
  logic         dataReady = 1'b0;
  logic [7:0]   dataByte;
  logic [6:0]   dataId;
  logic         busy;
  logic         overflow;
  logic [7:0]   lostFrames;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];
  logic [7:0]  fb[16];

  tpiu_frame_demux #(.DROP_NULL_ID(1'b1)) dut (
    .traceClkin (traceClkin),
    .rst        (rst),
    .FrAvail    (FrAvail),
    .Frame      (Frame),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .dataByte   (dataByte),
    .dataId     (dataId),
    .busy       (busy),
    .overflow   (overflow),
    .lostFrames (lostFrames)
  );

  always #5 traceClkin = ~traceClkin;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output against the scoreboard.
  always @(negedge traceClkin) begin
    if (!rst && dataValid && dataReady) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got id=%0h byte=%0h expected none",
                 dataId, dataByte);
      end else begin
        check("out_pair", {17'd0, dataId, dataByte}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [127:0] pack_fb();
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = fb[n];
    return r;
  endfunction

  task automatic tick();
    @(posedge traceClkin);
    #1;
  endtask

  task automatic push(input logic [6:0] id, input logic [7:0] b);
    exp_q.push_back({id, b});
  endtask

  task automatic clear_fb();
    for (int n = 0; n < 16; n++) fb[n] = 8'h00;
  endtask

  task automatic ramp_fb();
    for (int n = 0; n < 15; n++) fb[n] = 8'(8'h10 * n);
    fb[15] = 8'h00;
  endtask

  task automatic send();
    Frame   = pack_fb();
    FrAvail = ~FrAvail;
    tick();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy || dataValid) && k < 400) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, 32'(k < 400), 32'd1);
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    FrAvail   = 1'b0;
    dataReady = 1'b0;
    Frame     = '0;
    tick();
    check("reset_outs",
          {9'd0, dataValid, dataByte, dataId, busy, overflow, lostFrames},
          32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_s1();
    clear_fb();
    fb[0] = 8'h03; fb[1] = 8'h41; fb[2] = 8'h84; fb[3] = 8'h22;
    fb[4] = 8'h05; fb[5] = 8'h33; fb[6] = 8'h10; fb[15] = 8'h06;
    push(7'd1, 8'h41); push(7'd1, 8'h85); push(7'd1, 8'h22);
    push(7'd1, 8'h33); push(7'd2, 8'h10);
    for (int n = 7; n < 15; n++) push(7'd2, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int vcnt;
    int k;

    do_reset();

    // 1: immediate and deferred ID change
    load_s1();
    dataReady = 1'b1;
    send();
    drain("t1");

    // 2: null ID bytes are dropped
    do_reset();
    for (int n = 0; n < 15; n++) fb[n] = 8'hAA;
    fb[15] = 8'h00;
    dataReady = 1'b1;
    send();
    bcnt = 0;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy) bcnt++;
      if (dataValid) vcnt++;
      tick();
    end
    check("t2_busy_cycles", 32'(bcnt), 32'd15);
    check("t2_valid_cycles", 32'(vcnt), 32'd0);

    // 3: backpressure holds the first byte
    do_reset();
    load_s1();
    send();
    k = 0;
    while (!dataValid && k < 20) begin
      tick();
      k++;
    end
    check("t3_first_valid", 32'(dataValid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("t3_hold", {23'd0, dataValid, dataByte}, {23'd0, 1'b1, 8'h41});
      tick();
    end
    dataReady = 1'b1;
    drain("t3");

    // 4: pending buffer and overflow, curId is 2 here
    dataReady = 1'b0;
    ramp_fb();
    for (int n = 0; n < 15; n++) push(7'd2, 8'(8'h10 * n));
    send();
    repeat (3) tick();
    for (int n = 0; n < 15; n++) fb[n] = 8'(8'h10 * n + 2);
    for (int n = 0; n < 15; n++) push(7'd2, 8'(8'h10 * n + 2));
    send();
    check("t4_no_ovf_pend", 32'(overflow), 32'd0);
    repeat (3) tick();
    fb[0] = 8'hEE;
    send();
    check("t4_ovf_pulse", 32'(overflow), 32'd1);
    check("t4_lost", 32'(lostFrames), 32'd1);
    tick();
    check("t4_ovf_clear", 32'(overflow), 32'd0);
    dataReady = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (dataValid) vcnt++;
      tick();
    end
    check("t4_back_to_back", 32'(vcnt), 32'd30);
    drain("t4");
    check("t4_lost_hold", 32'(lostFrames), 32'd1);

    // 5: slot 14 deferred ID applies at frame end
    clear_fb();
    fb[14] = 8'h0B;
    fb[15] = 8'h80;
    for (int n = 0; n < 14; n++) push(7'd2, 8'h00);
    send();
    drain("t5a");
    ramp_fb();
    for (int n = 0; n < 15; n++) push(7'd5, 8'(8'h10 * n));
    send();
    drain("t5b");

    // 6: reset in the middle of a frame
    ramp_fb();
    for (int n = 0; n < 5; n++) push(7'd5, 8'(8'h10 * n));
    send();
    repeat (6) tick();
    rst     = 1'b1;
    FrAvail = 1'b0;
    #1;
    check("t6_rst_outs",
          {9'd0, dataValid, dataByte, dataId, busy, overflow, lostFrames},
          32'd0);
    check("t6_seen", 32'(exp_q.size()), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    clear_fb();
    fb[0] = 8'h40; fb[1] = 8'h09; fb[2] = 8'h07; fb[3] = 8'h99;
    push(7'd3, 8'h99);
    for (int n = 4; n < 15; n++) push(7'd3, 8'h00);
    send();
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpiu_frame_demux.md
Name: tpiu_frame_demux

Overview:
- Sits directly downstream of the trace pin interface, in the traceClkin domain.
- Takes each completed 16-byte TPIU frame and decodes the CoreSight formatter protocol: ID-change bytes, auxiliary LSB byte and deferred ID switches.
- Emits a stream of (stream ID, data byte) pairs over a valid/ready handshake to the downstream packet FIFO.
- Buffers one pending frame so short consumer stalls do not lose frames.

Parameters:
- DROP_NULL_ID, 1, when 1, data bytes whose current stream ID is 0x00 are discarded and not emitted.

Ports:
- traceClkin  input  1  trace clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- FrAvail  input  1  toggles once per new frame from the upstream stage.
- Frame  input  128  frame; byte n = Frame[127-8n -: 8], so byte 0 is [127:120] and byte 15 (aux) is [7:0]; stable from toggle until the next toggle.
- dataValid  output  1  output byte available.
- dataReady  input  1  consumer accepts when dataValid && dataReady at an edge.
- dataByte  output  8  decoded data byte.
- dataId  output  7  stream ID associated with dataByte.
- busy  output  1  working frame in progress.
- overflow  output  1  one-cycle pulse when a frame is dropped.
- lostFrames  output  8  count of dropped frames, saturating at 0xFF.

Behaviour:
- Reset values: dataValid=0, dataByte=0, dataId=0, busy=0, overflow=0, lostFrames=0.
- Internal reset values: curId=0, lastAv=0, pending and working buffers empty, no deferred ID, state IDLE.
- Frame detect: newFrame = (FrAvail != lastAv); lastAv<=FrAvail every edge.
- On newFrame:
  - If the working buffer is free, or is freed on this same edge, the frame goes there (idx=0).
  - Else if pending is empty, the frame goes to pending.
  - Else drop it: overflow=1 for one cycle and lostFrames+1 (saturating).
- States:
  - IDLE: busy=0; go to RUN when a frame is loaded.
  - RUN: busy=1; process slot idx (0..14), at most one slot per edge.
- Advance: a slot is processed only if it emits nothing, or the output register is empty or being accepted on this edge. Otherwise idx holds (stall).
- Even slot i (pair k=i/2), aux bit = byte15[k]:
  - bit0=1 (ID change), newId = byte[7:1]:
    - aux=0: curId<=newId now.
    - aux=1: store deferred = newId; it applies after the next data byte (slot i+1) is emitted or dropped.
    - Slot 14 with aux=1: apply at frame end.
    - No output for an ID-change slot.
  - bit0=0: data = {byte[7:1], aux}, tagged with curId.
- Odd slot i (1..13): data = byte, tagged with curId. After this slot, any deferred ID is applied.
- Emit: a data slot loads dataByte/dataId and sets dataValid=1, unless DROP_NULL_ID && curId==0, in which case the byte is dropped silently.
- dataValid stays 1 and dataByte/dataId stay stable until accepted. dataValid falls on the accept edge unless a new byte is loaded on that same edge.
- End of frame (slot 14 processed):
  - Apply any remaining deferred ID.
  - If pending is full, move it to working, idx=0, stay in RUN with no bubble.
  - Else go to IDLE.
  - A newFrame arriving on this same edge lands in working if pending was empty, otherwise in pending.
- curId persists across frames; only rst clears it.
- Latency: toggle seen at edge E → slot 0 processed at E+1 → dataValid high after E+1 (if slot 0 is data). A full frame with no stalls drains in 15 edges.
- Frame content is copied into the buffers on detection; later changes on the Frame bus do not affect a buffered frame.
- Reset mid-frame: all buffers are discarded and the partial frame is not emitted.

Test Plan:
1. ID change, then deferred ID:
   - Stimulus: dataReady=1; frame bytes: 0=0x03, 1=0x41, 2=0x84, 3=0x22, 4=0x05, 5=0x33, 6=0x10, rest 0x00 with even bytes bit0=0; byte15=0x06 (aux1=1, aux2=1).
   - Required emitted (id,byte): (1,0x41), (1,0x85), (1,0x22), (1,0x33), (2,0x10).
   - Subsequent 0x00 bytes with id 2 follow: slots 7–14 give 8 bytes.
2. Null ID filtering:
   - Stimulus: after reset (curId=0), frame of all data 0xAA (even bytes 0xAA, aux 0x00), DROP_NULL_ID=1.
   - Required: no dataValid asserted; busy high for exactly 15 cycles.
3. Backpressure:
   - Stimulus: scenario 1 frame, dataReady=0 for 10 cycles after the first dataValid.
   - Required: dataByte holds 0x41 for the whole stall, then the same sequence emits in order with nothing lost.
4. Buffering and overflow:
   - Stimulus: dataReady=0; 3 FrAvail toggles 4 cycles apart.
   - Required: frames 1 and 2 are held; third toggle → overflow pulse, lostFrames=1.
   - Then dataReady=1: frames 1 and 2 drain back-to-back with no idle cycle.
5. Slot 14 ID change with aux7=1:
   - Stimulus: frame with byte14=0x0B.
   - Required: curId becomes 5 at frame end; first data of the next frame is tagged 5.
6. Reset mid-frame:
   - Stimulus: assert rst at slot 6.
   - Required: all outputs immediately 0, lostFrames=0; the next frame decodes with curId=0.
